ct_split: RTL and testbench
===========================

Name: ct_split

Overview:
- Packet-aware 1-to-NO fork/demux on valid/ready/eop streams; the upstream counterpart of the NI-to-1 merge stage in the crossbar.
- Each packet goes to the subset of outputs selected by a destination mask, which is sampled on the packet's first beat and held until eop.
- Broadcast (multi-bit mask) is supported. A beat retires only after every targeted output has accepted it.
- Per-output "done" flags let outputs accept the same beat on different cycles.

Parameters:
NO, 2, number of outputs (>=1)
WIDTH, 1, data width per beat

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
i_data  in  WIDTH  input beat data
i_valid  in  1  input beat valid
o_ready  out  1  input beat consumed this cycle
i_eop  in  1  last beat of packet
i_mask  in  NO  destination mask; sampled on first beat of packet only
o_data  out  NO*WIDTH  per-output data; slice k = i_data
o_valid  out  NO  per-output valid
i_ready  in  NO  per-output ready
o_eop  out  NO  per-output eop; every bit = i_eop

Behaviour:
- Interface rule: clk is the only clock. reset is synchronous and active-low; it is sampled on the clk rising edge while low.
- State: mode (SOP/BODY), pkt_mask[NO-1:0], done[NO-1:0].
- Reset (reset low at an edge): mode=SOP, pkt_mask=0, done=0.
  - While reset is low, o_valid=0 and o_ready=0 (gated combinationally).
- Active mask: eff_mask = (mode==SOP) ? i_mask : pkt_mask.
- Outputs are combinational, with zero latency:
  - o_valid[k] = i_valid & eff_mask[k] & !done[k]
  - o_data slice k = i_data
  - o_eop[k] = i_eop
- Per-output accept: acc[k] = o_valid[k] & i_ready[k].
- Beat complete: fin = i_valid & AND over k of (!eff_mask[k] | done[k] | acc[k]).
  - o_ready = fin.
  - o_ready may depend combinationally on i_valid, i_mask and i_ready. Upstream must not make i_valid depend on o_ready.
- Register updates each clk edge (reset high):
  - if fin: done <= 0
  - else: done <= done | acc (only when i_valid)
  - if fin & mode==SOP & !i_eop: pkt_mask <= i_mask, mode <= BODY
  - if fin & i_eop: mode <= SOP
  - pkt_mask retains its value when not loaded.
- Single-beat packet (eop on first beat): uses i_mask live; mode stays SOP; pkt_mask is not updated.
- Zero mask: all o_valid=0 and fin = i_valid, so the beat or packet is dropped at one beat per cycle. A zero mask latched in SOP applies to the whole packet.
- Partial acceptance: outputs already done hold o_valid low for that beat; the remaining outputs keep o_valid high with the same data until they accept.
  - Upstream must hold i_data, i_eop and i_valid stable while o_ready=0 (AXI-style).
- i_mask changes in BODY mode are ignored.
- i_mask changes in SOP mode between cycles of a stalled first beat are illegal. The bench asserts i_mask is stable while i_valid & !o_ready & mode==SOP.
- Ordering: beats retire in order; no beat is duplicated to an output; each targeted output sees every packet beat exactly once.
- Throughput: 1 beat/cycle when all targeted i_ready are high.
- Reset mid-packet: state returns to SOP and partial done flags are lost. The next i_valid beat is treated as a first beat.

Test Plan:
- NO=4, WIDTH=8; unicast 3-beat packet, i_mask=0100 on beat 0 and 0001 on beats 1-2, all ready → only o_valid[2] pulses, 3 consecutive cycles; data 0x11,0x22,0x33; o_eop on 3rd; o_ready high 3 cycles.
- Broadcast i_mask=1011, 1-beat packet, i_ready[0]=1 in cycle 0, i_ready[1] in cycle 1, i_ready[3] in cycle 2 → o_valid drops per output after accept (1011→1010→1000→0000 after fin); o_ready high only in cycle 2; each output accepts exactly once.
- i_mask=0000, 2-beat packet → all o_valid=0, o_ready=1 both cycles; mode back to SOP after eop.
- Back-to-back packets: single-beat to 0001, then 2-beat to 0010, all ready → 3 beats in 3 cycles; second packet routed to output 1 only.
- Reset driven low mid-packet during a broadcast with done=0001 → next cycle o_valid=0 and o_ready=0. After release, a new beat with i_mask=0001 reaches output 0 even though it had accepted the prior beat.

Source files
------------

// File: rtl/ct_split_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ct_split_if : stream bundle between an upstream source, the fork   |
// |               and its NO downstream sinks.                         |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
interface ct_split_if #(
  parameter int NO    = 2,
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0]    i_data;
  logic                i_valid;
  logic                o_ready;
  logic                i_eop;
  logic [NO-1:0]       i_mask;
  logic [NO*WIDTH-1:0] o_data;
  logic [NO-1:0]       o_valid;
  logic [NO-1:0]       i_ready;
  logic [NO-1:0]       o_eop;

  modport slave (
    input  i_data, i_valid, i_eop, i_mask, i_ready,
    output o_ready, o_data, o_valid, o_eop
  );

  modport master (
    output i_data, i_valid, i_eop, i_mask, i_ready,
    input  o_ready, o_data, o_valid, o_eop
  );
endinterface
`default_nettype wire

// File: rtl/ct_split.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ct_split : packet-aware 1-to-NO fork; a beat retires once every    |
// |            output in the packet's destination mask has taken it.   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module ct_split #(
  parameter int NO    = 2,
  parameter int WIDTH = 1
) (
  input  logic       clk,
  input  logic       reset,
  ct_split_if.slave  bus
);

  typedef enum logic [0:0] {
    MODE_SOP  = 1'b0,
    MODE_BODY = 1'b1
  } mode_e;

  mode_e         mode_q,     mode_d;
  logic [NO-1:0] pkt_mask_q, pkt_mask_d;
  logic [NO-1:0] done_q,     done_d;

  logic [NO-1:0] eff_mask;
  logic [NO-1:0] valid_w;
  logic [NO-1:0] acc;
  logic          fin;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q     <= MODE_SOP;
      pkt_mask_q <= '0;
      done_q     <= '0;
    end else begin
      mode_q     <= mode_d;
      pkt_mask_q <= pkt_mask_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    mode_d     = mode_q;
    pkt_mask_d = pkt_mask_q;
    done_d     = done_q;

    // First beat routes on the live mask; the rest of the packet uses the latched copy.
    eff_mask = (mode_q == MODE_SOP) ? bus.i_mask : pkt_mask_q;
    valid_w  = {NO{reset & bus.i_valid}} & eff_mask & ~done_q;
    acc      = valid_w & bus.i_ready;
    fin      = reset & bus.i_valid & (&(~eff_mask | done_q | acc));

    if (fin) begin
      done_d = '0;
      if (bus.i_eop) begin
        mode_d = MODE_SOP;
      end else if (mode_q == MODE_SOP) begin
        pkt_mask_d = bus.i_mask;
        mode_d     = MODE_BODY;
      end
    end else if (bus.i_valid) begin
      done_d = done_q | acc;
    end
  end

  assign bus.o_valid = valid_w;
  assign bus.o_ready = fin;
  assign bus.o_data  = {NO{bus.i_data}};
  assign bus.o_eop   = {NO{bus.i_eop}};

endmodule
`default_nettype wire

// File: tb/tb_ct_split.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ct_split : directed vector bench for ct_split (NO=4, WIDTH=8).  |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module tb_ct_split;

  localparam int NO    = 4;
  localparam int WIDTH = 8;

  typedef struct {
    logic             rst_n;
    logic             vld;
    logic             eop;
    logic [NO-1:0]    mask;
    logic [WIDTH-1:0] data;
    logic [NO-1:0]    rdy;
    logic [NO-1:0]    exp_ov;
    logic             exp_ordy;
  } vec_t;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  vec_t vecs[$];

  ct_split_if #(.NO(NO), .WIDTH(WIDTH)) bus ();

  ct_split #(.NO(NO), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Drive one cycle of inputs just after a rising edge, check mid-cycle, advance.
  task automatic apply(input vec_t v, input string tag);
    reset       = v.rst_n;
    bus.i_valid = v.vld;
    bus.i_eop   = v.eop;
    bus.i_mask  = v.mask;
    bus.i_data  = v.data;
    bus.i_ready = v.rdy;
    #3;
    check({tag, ".o_valid"}, 32'(bus.o_valid), 32'(v.exp_ov));
    check({tag, ".o_ready"}, 32'(bus.o_ready), 32'(v.exp_ordy));
    check({tag, ".o_data"},  32'(bus.o_data),  32'({NO{v.data}}));
    check({tag, ".o_eop"},   32'(bus.o_eop),   32'({NO{v.eop}}));
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic r, logic vl, logic e, logic [3:0] m, logic [7:0] d,
                              logic [3:0] rd, logic [3:0] ov, logic ordy);
    vec_t v;
    v.rst_n = r;  v.vld = vl; v.eop = e;    v.mask = m;
    v.data  = d;  v.rdy = rd; v.exp_ov = ov; v.exp_ordy = ordy;
    return v;
  endfunction

  // Upstream legality: a stalled first beat must keep its mask.
  logic          hold_q;
  logic          sop_q;
  logic [NO-1:0] mask_q;
  initial begin
    hold_q = 1'b0;
    sop_q  = 1'b1;
    mask_q = '0;
  end
  always @(posedge clk) begin
    if (reset && hold_q && bus.i_mask !== mask_q) begin
      $display("FAIL mask_stable: got %b, expected %b", bus.i_mask, mask_q);
      n_total++;
    end
    hold_q <= reset & bus.i_valid & ~bus.o_ready & sop_q;
    mask_q <= bus.i_mask;
    if (!reset)                        sop_q <= 1'b1;
    else if (bus.i_valid & bus.o_ready) sop_q <= bus.i_eop;
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_eop   = 1'b0;
    bus.i_mask  = '0;
    bus.i_data  = '0;
    bus.i_ready = '0;

    //              rst vld eop mask     data   rdy      exp_ov   ordy
    // reset gating and idle
    vecs.push_back(mk(0, 1, 0, 4'b1111, 8'h00, 4'b1111, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 1, 4'b1111, 8'h01, 4'b1111, 4'b0000, 0));
    vecs.push_back(mk(1, 0, 0, 4'b1111, 8'h02, 4'b1111, 4'b0000, 0));
    // unicast 3-beat to output 2; later mask changes ignored
    vecs.push_back(mk(1, 1, 0, 4'b0100, 8'h11, 4'b1111, 4'b0100, 1));
    vecs.push_back(mk(1, 1, 0, 4'b0001, 8'h22, 4'b1111, 4'b0100, 1));
    vecs.push_back(mk(1, 1, 1, 4'b0001, 8'h33, 4'b1111, 4'b0100, 1));
    // broadcast 1011, outputs accept on different cycles
    vecs.push_back(mk(1, 1, 1, 4'b1011, 8'h44, 4'b0001, 4'b1011, 0));
    vecs.push_back(mk(1, 1, 1, 4'b1011, 8'h44, 4'b0010, 4'b1010, 0));
    vecs.push_back(mk(1, 1, 1, 4'b1011, 8'h44, 4'b1000, 4'b1000, 1));
    vecs.push_back(mk(1, 0, 0, 4'b1011, 8'h00, 4'b0000, 4'b0000, 0));
    // zero-mask 2-beat packet dropped; SOP afterwards uses live mask
    vecs.push_back(mk(1, 1, 0, 4'b0000, 8'h55, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(1, 1, 1, 4'b1111, 8'h56, 4'b1111, 4'b0000, 1));
    vecs.push_back(mk(1, 1, 1, 4'b0001, 8'h66, 4'b0000, 4'b0001, 0));
    vecs.push_back(mk(1, 1, 1, 4'b0001, 8'h66, 4'b0001, 4'b0001, 1));
    // back-to-back: single beat to 0, then 2-beat to 1
    vecs.push_back(mk(1, 1, 1, 4'b0001, 8'h77, 4'b1111, 4'b0001, 1));
    vecs.push_back(mk(1, 1, 0, 4'b0010, 8'h88, 4'b1111, 4'b0010, 1));
    vecs.push_back(mk(1, 1, 1, 4'b0001, 8'h99, 4'b1111, 4'b0010, 1));
    // body-beat stall with latched mask 1100
    vecs.push_back(mk(1, 1, 0, 4'b1100, 8'hA0, 4'b1111, 4'b1100, 1));
    vecs.push_back(mk(1, 1, 1, 4'b0011, 8'hA1, 4'b0100, 4'b1100, 0));
    vecs.push_back(mk(1, 1, 1, 4'b0011, 8'hA1, 4'b1000, 4'b1000, 1));

    @(posedge clk);
    #1;
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-packet after output 0 accepted a broadcast beat
    apply(mk(1, 1, 0, 4'b0011, 8'hB0, 4'b0001, 4'b0011, 0), "rst.pre");
    apply(mk(1, 1, 0, 4'b0011, 8'hB0, 4'b0000, 4'b0010, 0), "rst.done");
    apply(mk(0, 1, 0, 4'b0011, 8'hB0, 4'b1111, 4'b0000, 0), "rst.low");
    apply(mk(1, 1, 1, 4'b0001, 8'hC0, 4'b0000, 4'b0001, 0), "rst.new");
    apply(mk(1, 1, 1, 4'b0001, 8'hC0, 4'b0001, 4'b0001, 1), "rst.acc");
    apply(mk(1, 0, 0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 0), "rst.idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
